// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared types and constants for the ID/EX pipeline stage.
//   ctrl_t   - packed control bundle carried from decode into execute
//   state_t  - stage sequencing state (RUN / BUBBLE)
//   ZERO_REG - architectural x0, never forwarded and never a hazard source
package id_ex_pkg;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] result_src;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Bit positions of single-bit fields inside the packed ctrl_t above.
  localparam int CTRL_REG_WRITE = 4;
  localparam int CTRL_MEM_READ  = 3;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: combinational operand select for one EX source register.
//   fwd_en        - 0 passes cap_val straight through
//   src           - EX source register address
//   cap_val       - value captured at the ID/EX edge
//   mem_* / wb_*  - writer valid, destination and result of MEM and WB
//   op            - selected operand (MEM beats WB beats captured value)
module fwd_mux
  import id_ex_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  fwd_en,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [DATA_WIDTH-1:0] cap_val,
  input  logic                  mem_reg_write,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  wb_reg_write,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_result,
  output logic [DATA_WIDTH-1:0] op
);

  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(ZERO_REG);

  always_comb begin
    op = cap_val;
    if (fwd_en && src != X0) begin
      if (mem_reg_write && mem_rd == src) begin
        op = mem_result;
      end else if (wb_reg_write && wb_rd == src) begin
        op = wb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with load-use bubble
// insertion, capture-time WB bypass and EX-time MEM/WB forwarding.
//
// Config macro: ID_EX_FORWARD_EN
//   defined   - EX-time MEM/WB forwarding; one bubble per load-use hazard
//   undefined - no EX-time forwarding; bubbles repeat while any source
//               matches a pending writer in EX or MEM
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   id_*                        decoded instruction and register-file reads
//   flush                       kill the instruction being captured
//   ex_ready                    low freezes the stage
//   mem_reg_write/mem_rd/_result  EX/MEM writer
//   wb_reg_write/wb_rd/_result    WB writer (same-cycle regfile write)
//   id_stall                    hold PC and IF/ID
//   ex_*                        registered EX-stage view; ex_op_a/b forwarded
//
// state  | meaning
// RUN    | normal capture; hazard check active
// BUBBLE | a bubble was just inserted; consumer recaptured next edge
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = CTRL_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [ADDR_WIDTH-1:0] id_rs1,
  input  logic [ADDR_WIDTH-1:0] id_rs2,
  input  logic [ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0] id_rd1,
  input  logic [DATA_WIDTH-1:0] id_rd2,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic                  flush,
  input  logic                  ex_ready,
  input  logic                  mem_reg_write,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_result,
  input  logic                  wb_reg_write,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_result,
  output logic                  id_stall,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [ADDR_WIDTH-1:0] ex_rs1,
  output logic [ADDR_WIDTH-1:0] ex_rs2,
  output logic [ADDR_WIDTH-1:0] ex_rd,
  output logic [CTRL_WIDTH-1:0] ex_ctrl,
  output logic [DATA_WIDTH-1:0] ex_op_a,
  output logic [DATA_WIDTH-1:0] ex_op_b
);

  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(ZERO_REG);

  state_t                state;
  logic [DATA_WIDTH-1:0] ex_val1;
  logic [DATA_WIDTH-1:0] ex_val2;
  logic [DATA_WIDTH-1:0] cap_rd1;
  logic [DATA_WIDTH-1:0] cap_rd2;
  logic                  hazard;
  logic                  fwd_en;

  // The register file only exposes a WB write after the edge, so pick the
  // WB result up directly when it targets a source being captured now.
  always_comb begin
    cap_rd1 = id_rd1;
    cap_rd2 = id_rd2;
    if (wb_reg_write && wb_rd != X0 && wb_rd == id_rs1) cap_rd1 = wb_result;
    if (wb_reg_write && wb_rd != X0 && wb_rd == id_rs2) cap_rd2 = wb_result;
  end

`ifdef ID_EX_FORWARD_EN
  assign fwd_en = 1'b1;

  // Only a load in EX needs a bubble; everything else is forwarded.
  assign hazard = (state == RUN) && ex_valid && ex_ctrl[CTRL_MEM_READ] &&
                  ex_rd != X0 && id_valid &&
                  (ex_rd == id_rs1 || ex_rd == id_rs2);
`else
  assign fwd_en = 1'b0;

  // Without forwarding, any pending writer in EX or MEM blocks the reader.
  // In BUBBLE, EX is empty so only the MEM term can still hold the stall.
  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;

  assign ex_hit1  = (state == RUN) && ex_valid && ex_ctrl[CTRL_REG_WRITE] &&
                    ex_rd == id_rs1;
  assign ex_hit2  = (state == RUN) && ex_valid && ex_ctrl[CTRL_REG_WRITE] &&
                    ex_rd == id_rs2;
  assign mem_hit1 = mem_reg_write && mem_rd == id_rs1;
  assign mem_hit2 = mem_reg_write && mem_rd == id_rs2;

  assign hazard = id_valid &&
                  ((id_rs1 != X0 && (ex_hit1 || mem_hit1)) ||
                   (id_rs2 != X0 && (ex_hit2 || mem_hit2)));
`endif

  assign id_stall = !rst && !flush && (hazard || !ex_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_imm   <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_ctrl  <= '0;
      ex_val1  <= '0;
      ex_val2  <= '0;
    end else if (flush) begin
      state    <= RUN;
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (ex_ready) begin
      if (hazard) begin
        state    <= BUBBLE;
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else begin
        state    <= RUN;
        ex_valid <= id_valid;
        ex_pc    <= id_pc;
        ex_imm   <= id_imm;
        ex_rs1   <= id_rs1;
        ex_rs2   <= id_rs2;
        ex_rd    <= id_rd;
        ex_ctrl  <= id_ctrl;
        ex_val1  <= cap_rd1;
        ex_val2  <= cap_rd2;
      end
    end
  end

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_a (
    .fwd_en        (fwd_en),
    .src           (ex_rs1),
    .cap_val       (ex_val1),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .op            (ex_op_a)
  );

  fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_b (
    .fwd_en        (fwd_en),
    .src           (ex_rs2),
    .cap_val       (ex_val2),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .op            (ex_op_b)
  );

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage, directly downstream of the register file. Consumes the rs1/rs2 read data, decoded control and immediate.
- Registers these values into the EX stage and inserts load-use bubbles.
- Applies MEM/WB operand forwarding.
- Bypasses same-cycle WB writes, which the register file does not expose until the following edge.

Parameters:
- DATA_WIDTH, 32, width of operands, immediate, PC and forwarded results.
- ADDR_WIDTH, 5, register address width.
- CTRL_WIDTH, 10, packed control bundle width (layout fixed by the package).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_pc  in  DATA_WIDTH  instruction PC.
- id_rs1, id_rs2, id_rd  in  ADDR_WIDTH  source and destination register addresses.
- id_rd1, id_rd2  in  DATA_WIDTH  register file read data.
- id_imm  in  DATA_WIDTH  sign-extended immediate.
- id_ctrl  in  CTRL_WIDTH  fields: alu_ctrl[3:0], alu_src, reg_write, mem_read, mem_write, result_src[1:0].
- flush  in  1  branch/jump redirect; kill the instruction being captured.
- ex_ready  in  1  EX can accept; low freezes this stage.
- mem_reg_write  in  1  EX/MEM writer valid.
- mem_rd  in  ADDR_WIDTH  EX/MEM destination.
- mem_result  in  DATA_WIDTH  EX/MEM ALU result.
- wb_reg_write  in  1  WB writer valid.
- wb_rd  in  ADDR_WIDTH  WB destination.
- wb_result  in  DATA_WIDTH  WB write data (same value driven to the register file din).
- id_stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a valid instruction.
- ex_pc, ex_imm  out  DATA_WIDTH  registered PC and immediate.
- ex_rs1, ex_rs2, ex_rd  out  ADDR_WIDTH  registered register addresses.
- ex_ctrl  out  CTRL_WIDTH  registered control bundle.
- ex_op_a, ex_op_b  out  DATA_WIDTH  forwarded rs1/rs2 operands (ex_op_b is before the alu_src mux).

Behaviour:
- Reset: all registered outputs are 0, FSM is in RUN, id_stall=0.
  - Reset asserted mid-operation clears in-flight state immediately; no partial capture survives.
- Update priority per edge: rst > flush > !ex_ready > load-use bubble > capture.
- flush:
  - ex_valid<=0 and ex_ctrl<=0.
  - Other fields are don't-care.
  - FSM goes to RUN.
  - Flush overrides a pending bubble or hold.
- !ex_ready:
  - All registers hold.
  - id_stall=1.
  - Downstream MEM/WB are frozen by their owners.
- Load-use hazard:
  - Condition: ex_valid & ex_ctrl.mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
  - Response: id_stall=1, bubble inserted (ex_valid<=0, ex_ctrl<=0), FSM RUN->BUBBLE.
- BUBBLE:
  - Lasts exactly one cycle.
  - The consumer is recaptured normally at the next edge; FSM->RUN.
  - The load is then in WB when the consumer is in EX.
- Capture:
  - All id_* values are registered; ex_valid<=id_valid.
  - Latency from ID inputs to ex_* outputs is 1 cycle.
- Capture-time WB bypass:
  - If wb_reg_write & wb_rd!=0 & wb_rd==id_rs1, capture wb_result instead of id_rd1.
  - Same rule for rs2.
- EX-time forwarding (combinational from the registered values):
  - ex_op_a = mem_result if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1.
  - Otherwise ex_op_a = wb_result if the equivalent WB condition holds.
  - Otherwise ex_op_a = the captured rs1 value.
  - MEM has priority over WB; ex_op_b uses the same rule on ex_rs2.
- Register x0 is never bypassed or forwarded, and never causes a hazard.
- id_stall is combinational: (load-use hazard in RUN) | !ex_ready. It is never asserted during flush.

Optional Feature:
- Macro ID_EX_FORWARD_EN.
- Defined: EX-time MEM/WB forwarding and the single-bubble load-use handling, as described above.
- Undefined:
  - ex_op_a/ex_op_b are the captured values only; the capture-time WB bypass is retained.
  - Hazard condition becomes: id_valid and a source (!=0) matches either
    - ex_rd with ex_valid & ex_ctrl.reg_write, or
    - mem_rd with mem_reg_write.
  - Bubbles are inserted repeatedly (BUBBLE re-entered) until no match remains.

Decomposition:
- Package id_ex_pkg holds:
  - the packed ctrl_t struct (alu_ctrl, alu_src, reg_write, mem_read, mem_write, result_src) with CTRL_WIDTH derived from it;
  - the state enum {RUN, BUBBLE};
  - the ZERO_REG constant 5'd0.
- One sub-module, fwd_mux: a combinational single-operand MEM/WB select, instantiated twice.

Test Plan:
1. Reset mid-stream: assert rst with ex_valid=1 -> all ex_* outputs=0 and id_stall=0 immediately, before the next edge.
2. Back-to-back RAW:
   - add x5 sits in MEM with mem_result=0x1234.
   - Consumer in EX has ex_rs1=5 and captured value 0xDEAD.
   - Response: ex_op_a=0x1234. With WB also writing x5=0x9999, MEM still wins: 0x1234.
3. Load-use:
   - lw x6 in EX; id_rs2=6.
   - Response: id_stall=1 for exactly 1 cycle, then ex_valid=0 for one cycle.
   - Next cycle: consumer in EX and wb_rd=6, wb_result=0x42 -> ex_op_b=0x42.
4. Same-cycle WB bypass: wb_rd=3, wb_result=0x77, id_rs1=3, id_rd1=0 stale -> after the edge ex_op_a=0x77 (no MEM/WB match).
5. x0 guard: mem_rd=0, mem_reg_write=1, mem_result=0xFFFF, ex_rs1=0 -> ex_op_a keeps the captured value. A load to x0 with id_rs1=0 gives no stall.
6. Flush vs hold:
   - flush=1 with ex_ready=0 and a pending load-use -> ex_valid=0 next cycle and FSM returns to RUN.
   - ex_ready=0 alone -> all ex_* outputs unchanged over 3 cycles and id_stall=1.
